// File: rtl/matrix_seq_pkg.sv
// Shared types and constants for the sequential 2x2 matrix engine.
// The optional C-element saturation is selected by the MATRIX_SEQ_SAT_EN macro.
package matrix_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DET  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_PRODUCT = 1'b0;
  localparam logic MODE_DET     = 1'b1;

  localparam int MUL_CYCLES = 8;
  localparam int DET_CYCLES = 2;

endpackage

// File: rtl/matrix_2x2_seq_mul_acc.sv
// Shared signed WIDTHxWIDTH multiply-accumulate (module matrix_mul_acc).
// The sum output is the value the accumulator will take on an enabled edge.
module matrix_mul_acc
  import matrix_seq_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      acc_en,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic signed [2*WIDTH:0]   sum
);

  localparam int AW = 2 * WIDTH + 1;

  logic signed [AW-1:0] acc_reg;
  logic signed [AW-1:0] a_ext;
  logic signed [AW-1:0] b_ext;
  logic signed [AW-1:0] product;

  assign a_ext   = {{(AW-WIDTH){a[WIDTH-1]}}, a};
  assign b_ext   = {{(AW-WIDTH){b[WIDTH-1]}}, b};
  assign product = a_ext * b_ext;
  // clear restarts the running sum with the current product
  assign sum     = (clear ? '0 : acc_reg) + product;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (acc_en) begin
      acc_reg <= sum;
    end
  end

endmodule

// File: rtl/matrix_2x2_seq_engine.sv
// Sequential 2x2 matrix product / determinant engine with one shared multiplier.
// Define MATRIX_SEQ_SAT_EN to saturate C elements instead of wrapping them.
module matrix_2x2_seq_engine
  import matrix_seq_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [4*WIDTH-1:0]   matA,
  input  logic [4*WIDTH-1:0]   matB,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WIDTH-1:0]   result
);

  localparam int CW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + 1;
  localparam int DW = 4 * WIDTH;

  state_t               state_reg;
  logic [2:0]           step_reg;
  logic                 mode_reg;
  logic [4*WIDTH-1:0]   a_reg;
  logic [4*WIDTH-1:0]   b_reg;
  logic signed [CW-1:0] c_reg [4];
  logic signed [DW-1:0] det_reg;
  logic                 out_valid_reg;
  logic [8*WIDTH-1:0]   result_reg;

  logic signed [WIDTH-1:0] a_el [4];
  logic signed [WIDTH-1:0] b_el [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_unpack
      assign a_el[gi] = a_reg[(3-gi)*WIDTH +: WIDTH];
      assign b_el[gi] = b_reg[(3-gi)*WIDTH +: WIDTH];
    end
  endgenerate

  // step = {i, j, t}: C[i][j] += A[i][t] * B[t][j]
  logic signed [WIDTH-1:0] mul_a;
  logic signed [WIDTH-1:0] mul_b;
  logic signed [AW-1:0]    acc_sum;
  logic signed [CW-1:0]    c_red;

  assign mul_a = a_el[{step_reg[2], step_reg[0]}];
  assign mul_b = b_el[{step_reg[0], step_reg[1]}];

  matrix_mul_acc #(.WIDTH(WIDTH)) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (~step_reg[0]),
    .acc_en (state_reg == MUL),
    .a      (mul_a),
    .b      (mul_b),
    .sum    (acc_sum)
  );

`ifdef MATRIX_SEQ_SAT_EN
  always_comb begin
    c_red = acc_sum[CW-1:0];
    if (acc_sum[AW-1] != acc_sum[AW-2]) begin
      c_red = acc_sum[AW-1] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
    end
  end
`else
  logic unused_msb;
  assign unused_msb = acc_sum[AW-1];
  assign c_red      = acc_sum[CW-1:0];
`endif

  // Determinant terms use a separate 2W-wide multiplier, wrapping modulo 2^(4W)
  logic signed [CW-1:0] det_a;
  logic signed [CW-1:0] det_b;
  logic signed [DW-1:0] det_a_ext;
  logic signed [DW-1:0] det_b_ext;
  logic signed [DW-1:0] det_prod;
  logic signed [DW-1:0] det_final;

  assign det_a     = step_reg[0] ? c_reg[1] : c_reg[0];
  assign det_b     = step_reg[0] ? c_reg[2] : c_reg[3];
  assign det_a_ext = {{(DW-CW){det_a[CW-1]}}, det_a};
  assign det_b_ext = {{(DW-CW){det_b[CW-1]}}, det_b};
  assign det_prod  = det_a_ext * det_b_ext;
  assign det_final = det_reg - det_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      mode_reg      <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      det_reg       <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      for (int k = 0; k < 4; k++) c_reg[k] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= matA;
            b_reg     <= matB;
            mode_reg  <= mode;
            step_reg  <= '0;
            state_reg <= MUL;
          end
        end
        MUL: begin
          if (step_reg[0]) c_reg[step_reg[2:1]] <= c_red;
          step_reg <= step_reg + 3'd1;
          if (step_reg == 3'(MUL_CYCLES - 1)) begin
            step_reg <= '0;
            if (mode_reg == MODE_DET) begin
              state_reg <= DET;
            end else begin
              result_reg    <= {c_reg[0], c_reg[1], c_reg[2], c_red};
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        DET: begin
          if (step_reg == 3'(DET_CYCLES - 1)) begin
            result_reg    <= {{DW{det_final[DW-1]}}, det_final};
            out_valid_reg <= 1'b1;
            step_reg      <= '0;
            state_reg     <= DONE;
          end else begin
            det_reg  <= det_prod;
            step_reg <= step_reg + 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_matrix_2x2_seq_engine.sv
// Self-checking bench for matrix_2x2_seq_engine (WIDTH=7): vector table plus
// handwritten reset-abort and back-to-back sequences, scoreboarded results.
module tb_matrix_2x2_seq_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mode = 1'b0;
  logic [27:0] mat_a = '0;
  logic [27:0] mat_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [55:0] result;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  matrix_2x2_seq_engine #(.WIDTH(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .matA      (mat_a),
    .matB      (mat_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [55:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [55:0] drv_exp = '0;
  int          drv_lat = 0;
  logic        prev_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int el(input logic [27:0] v, input int k);
    logic signed [6:0] t;
    t = v[(3-k)*7 +: 7];
    return int'(t);
  endfunction

  function automatic int reduce_c(input int v);
    logic signed [13:0] t;
`ifdef MATRIX_SEQ_SAT_EN
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
`else
    t = v[13:0];
    return int'(t);
`endif
  endfunction

  function automatic logic [27:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {x0[6:0], x1[6:0], x2[6:0], x3[6:0]};
  endfunction

  function automatic logic [55:0] pk_c(input int c0, input int c1, input int c2, input int c3);
    return {c0[13:0], c1[13:0], c2[13:0], c3[13:0]};
  endfunction

  function automatic logic [55:0] sext_det(input longint d);
    logic signed [27:0] t;
    t = d[27:0];
    return {{28{t[27]}}, t};
  endfunction

  function automatic logic [55:0] model(input logic m, input logic [27:0] a, input logic [27:0] b);
    int c[2][2];
    longint d;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        c[i][j] = reduce_c(el(a, i*2) * el(b, j) + el(a, i*2+1) * el(b, 2+j));
    d = longint'(c[0][0]) * longint'(c[1][1]) - longint'(c[0][1]) * longint'(c[1][0]);
    if (m) return sext_det(d);
    return pk_c(c[0][0], c[0][1], c[1][0], c[1][1]);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) sb.push_back('{drv_exp, drv_lat, cyc + 1});
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_handshake", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.res));
          $display("op done: result=%014h expected=%014h", result, e.res);
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_accept();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_out();
    bit ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic m, input logic [27:0] a, input logic [27:0] b,
                        input logic [55:0] exp, input int hold);
    logic [55:0] snap;
    @(posedge clk); #1;
    mode = m; mat_a = a; mat_b = b; drv_exp = exp; drv_lat = m ? 10 : 8;
    in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    in_valid = 1'b0; mode = ~m; mat_a = 28'($urandom); mat_b = 28'($urandom);
    wait_out();
    snap = result;
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_result", 64'(result), 64'(snap));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic        m;
    logic [27:0] a;
    logic [27:0] b;
    logic [55:0] exp;
    int          hold;
  } vec_t;
  vec_t vecs[10];

  localparam int C34 =
`ifdef MATRIX_SEQ_SAT_EN
    8191;
`else
    -8192;
`endif

  initial begin
    logic [27:0] ident;
    logic [27:0] ra;
    logic [27:0] rb;
    bit saw;
    ident = pk(1, 0, 0, 1);

    vecs[0] = '{1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk_c(19, 22, 43, 50), 0};
    vecs[1] = '{1'b1, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 56'd4, 0};
    vecs[2] = '{1'b0, pk(-64, -64, 0, 0), pk(-64, 0, -64, 0), pk_c(C34, 0, 0, 0), 0};
    vecs[3] = '{1'b1, pk(2, 4, 1, 2), ident, 56'd0, 0};
    vecs[4] = '{1'b0, pk(2, 4, 1, 2), ident, pk_c(2, 4, 1, 2), 5};
    vecs[5] = '{1'b1, pk(63, -64, -64, 63), pk(-64, 63, -64, -64),
                model(1'b1, pk(63, -64, -64, 63), pk(-64, 63, -64, -64)), 0};
    vecs[6] = '{1'b0, pk(-64, -64, -64, -64), pk(-64, -64, -64, -64),
                model(1'b0, pk(-64, -64, -64, -64), pk(-64, -64, -64, -64)), 0};
    for (int k = 7; k < 10; k++) begin
      ra = 28'($urandom); rb = 28'($urandom);
      vecs[k] = '{k[0], ra, rb, model(k[0], ra, rb), 0};
    end

    // reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);

    for (int k = 0; k < 10; k++) begin
      $display("vector %0d: mode=%0d a=%07h b=%07h", k, vecs[k].m, vecs[k].a, vecs[k].b);
      run_op(vecs[k].m, vecs[k].a, vecs[k].b, vecs[k].exp, vecs[k].hold);
    end

    // reset in MUL cycle 4 aborts the operation
    @(posedge clk); #1;
    mode = 1'b0; mat_a = pk(1, 2, 3, 4); mat_b = pk(5, 6, 7, 8);
    drv_exp = pk_c(19, 22, 43, 50); drv_lat = 8; in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    saw = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    chk("abort_no_output", 64'(saw), 64'd0);
    $display("reset abort sequence done");
    run_op(1'b1, pk(3, -7, 5, 11), pk(-2, 9, 4, -6),
           model(1'b1, pk(3, -7, 5, 11), pk(-2, 9, 4, -6)), 0);

    // back-to-back with in_valid held high
    @(posedge clk); #1;
    mode = 1'b0; mat_a = pk(1, 2, 3, 4); mat_b = pk(5, 6, 7, 8);
    drv_exp = pk_c(19, 22, 43, 50); drv_lat = 8; in_valid = 1'b1;
    wait_accept();
    @(posedge clk); #1;
    mode = 1'b1; mat_a = pk(-5, 6, 7, -8); mat_b = pk(9, -10, 11, 12);
    drv_exp = model(1'b1, pk(-5, 6, 7, -8), pk(9, -10, 11, 12)); drv_lat = 10;
    wait_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_ready_after_hs", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_second_accepted", 64'(in_ready), 64'd0);
    wait_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("back-to-back sequence done");

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_2x2_seq_engine.md
MATRIX_2X2_SEQ_ENGINE -- requirements
Module: matrix_2x2_seq_engine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or reset inputs.
REQ-002 Parameter WIDTH, default 7, SHALL set the signed two's-complement width of each input matrix element.
REQ-003 Port clk, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the synchronous active-high reset.
REQ-005 Port in_valid, input, 1, SHALL signal that matA, matB and mode are valid.
REQ-006 Port in_ready, output, 1, SHALL signal that the block accepts a new operation.
REQ-007 Port mode, input, 1, SHALL select the result: 0 = product C = A*B, 1 = det(A*B).
REQ-008 Port matA, input, 4*WIDTH, SHALL be {A00,A01,A10,A11}, MSB first.
REQ-009 Port matB, input, 4*WIDTH, SHALL be {B00,B01,B10,B11}, MSB first.
REQ-010 Port out_valid, output, 1, SHALL signal that result is valid.
REQ-011 Port out_ready, input, 1, SHALL signal that the consumer takes result.
REQ-012 Port result, output, 8*WIDTH, SHALL be {C00,C01,C10,C11} (2*WIDTH each) in mode 0, or the 4*WIDTH determinant sign-extended to 8*WIDTH in mode 1.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DET and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in all other states it SHALL be 0.
REQ-015 On in_valid and in_ready both high at an edge, the block SHALL latch matA, matB and mode and enter MUL.
REQ-016 MUL SHALL use one signed WIDTHxWIDTH multiplier for 8 cycles, accumulating each C element over 2 products at 2*WIDTH+1 bits.
REQ-017 Each C element SHALL be reduced to 2*WIDTH bits per REQ-030 when its second product is accumulated.
REQ-018 After MUL, mode 0 SHALL go to DONE, and mode 1 SHALL go to DET.
REQ-019 DET SHALL take 2 cycles, computing C00*C11, then subtracting C01*C10, from the stored 2*WIDTH C values, then go to DONE.
REQ-020 The determinant SHALL wrap modulo 2^(4*WIDTH) and SHALL never saturate.
REQ-021 out_valid SHALL rise exactly 8 cycles after the accept edge in mode 0, and 10 cycles after it in mode 1.
REQ-022 In DONE, out_valid SHALL be 1 and result SHALL hold stable until out_ready is high at an edge.
REQ-023 On the out_valid and out_ready handshake, the block SHALL clear out_valid and return to IDLE, with in_ready high the next cycle; there is no overlap of operations.
REQ-024 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-025 mode changes after the accept edge SHALL have no effect on the current operation.

Reset
REQ-026 Reset SHALL force IDLE, out_valid=0, result=0 and in_ready=1 at the next edge.
REQ-027 Reset asserted mid-operation (MUL, DET or DONE) SHALL abort the operation with no output handshake.
REQ-028 Reset SHALL clear all accumulators and latched operands to 0.

Configuration
REQ-029 Macro MATRIX_SEQ_SAT_EN SHALL select the C-element reduction mode.
REQ-030 With MATRIX_SEQ_SAT_EN defined, C elements SHALL saturate to [-2^(2W-1), 2^(2W-1)-1]; without it, C elements SHALL truncate (wrap) to 2*WIDTH bits.

Structure
REQ-031 Package matrix_seq_pkg SHALL hold the state enum, the MODE_PRODUCT=0 and MODE_DET=1 constants, and the MUL_CYCLES=8 and DET_CYCLES=2 constants.
REQ-032 Sub-module matrix_mul_acc SHALL implement the shared signed multiply-accumulate with clear and accumulate-enable controls.

Verification (WIDTH=7)
REQ-033 Scenario: A=[[1,2],[3,4]], B=[[5,6],[7,8]], mode 0 -> C=[[19,22],[43,50]] 8 cycles after accept; mode 1 -> det=4 10 cycles after accept.
REQ-034 Scenario: A=[[-64,-64],[0,0]], B=[[-64,0],[-64,0]], mode 0 -> C00=8191 with MATRIX_SEQ_SAT_EN defined, C00=-8192 without it.
REQ-035 Scenario: A=[[2,4],[1,2]], B=I, mode 1 -> det=0; in mode 0 -> C=A.
REQ-036 Scenario: out_ready held low 5 cycles in DONE -> result stable, out_valid=1, in_ready=0, a new in_valid ignored.
REQ-037 Scenario: reset asserted in MUL cycle 4 -> next cycle IDLE, out_valid=0, result=0; a following operation gives a correct result.
REQ-038 Scenario: back-to-back operations with in_valid held high -> second accept occurs one cycle after the output handshake.
